// File: rtl/branch_redirect_ctrl_if.sv
// Redirect request bus from the branch redirect controller to fetch/PC-select.
// The master drives a valid/pc pair and holds it until the slave asserts ready.
interface branch_redirect_ctrl_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            redir_ready;

  modport master (
    output redir_valid,
    output redir_pc,
    input  redir_ready
  );

  modport slave (
    input  redir_valid,
    input  redir_pc,
    output redir_ready
  );

endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: takes a resolved EX-stage branch, issues a valid/ready
// redirect to fetch, flushes IF/ID while the redirect and its shadow drain, and stalls EX
// while busy. Taken branches to a misaligned target raise a one-cycle exception instead.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic                   ex_is_branch,
  input  logic                   ex_taken,
  input  logic [XLEN-1:0]        ex_target,
  output logic                   ex_ready,
  output logic                   stall_ex,
  branch_redirect_ctrl_if.master redir,
  output logic                   flush_if,
  output logic                   flush_id,
  output logic                   misalign_exc,
  output logic [CNT_W-1:0]       branch_cnt,
  output logic [CNT_W-1:0]       taken_cnt
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRedirect = 2'd1,
    StFlush    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            redir_valid_q, redir_valid_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;

  logic accept;
  logic aligned;

  assign ex_ready = (state_q == StIdle);
  assign stall_ex = ex_valid & ~ex_ready;
  assign accept   = ex_valid & ex_is_branch & ex_ready;
  assign aligned  = (ex_target[1:0] == 2'b00);

  // Next-state logic; registered outputs are decoded from the next state so they
  // line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    misalign_d = accept & ex_taken & ~aligned;
    unique case (state_q)
      StIdle: begin
        if (accept && ex_taken && aligned) begin
          pc_d    = ex_target;
          state_d = StRedirect;
        end
      end
      StRedirect: begin
        // redir_valid is high throughout this state, so ready alone completes it.
        if (redir.redir_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StFlush;
            cnt_d   = 4'(FLUSH_CYCLES);
          end
        end
      end
      StFlush: begin
        if (cnt_q <= 4'd1) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    redir_valid_d = (state_d == StRedirect);
    flush_d       = (state_d != StIdle);
  end

  // State and registered outputs; reset abandons any redirect or flush in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      pc_q          <= '0;
      redir_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pc_q          <= pc_d;
      redir_valid_q <= redir_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
    end
  end

  assign redir.redir_valid = redir_valid_q;
  assign redir.redir_pc    = pc_q;
  assign flush_if          = flush_q;
  assign flush_id          = flush_q;
  assign misalign_exc      = misalign_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  // Saturating statistics counters.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (accept && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (accept && ex_taken && aligned && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
`else
  assign branch_cnt = '0;
  assign taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: a table of single-branch transactions,
// hand-written sequences for backpressure, reset and counter saturation, and a
// scoreboard that checks every redirect PC at its handshake.
module tb_branch_redirect_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic            clk;
  logic            rst_n;
  logic            ex_valid;
  logic            ex_is_branch;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_ready;
  logic            stall_ex;
  logic            flush_if;
  logic            flush_id;
  logic            misalign_exc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  branch_redirect_ctrl_if #(.XLEN(XLEN)) rif ();

  branch_redirect_ctrl #(
    .XLEN        (XLEN),
    .FLUSH_CYCLES(2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_is_branch(ex_is_branch),
    .ex_taken    (ex_taken),
    .ex_target   (ex_target),
    .ex_ready    (ex_ready),
    .stall_ex    (stall_ex),
    .redir       (rif),
    .flush_if    (flush_if),
    .flush_id    (flush_id),
    .misalign_exc(misalign_exc),
    .branch_cnt  (branch_cnt),
    .taken_cnt   (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [XLEN-1:0] sb_q[$];

  typedef struct {
    logic            valid;
    logic            br;
    logic            taken;
    logic [XLEN-1:0] target;
    int              exp_rv;   // cycles with redir_valid
    int              exp_fl;   // cycles with flush_if / flush_id
    int              exp_mis;  // cycles with misalign_exc
    int              exp_rdy;  // first cycle after accept with ex_ready
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every redirect handshake must carry the oldest expected PC.
  always @(negedge clk) begin
    if (rst_n && rif.redir_valid && rif.redir_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got redirect 0x%0h, expected none", rif.redir_pc);
      end else begin
        check("sb_redir_pc", rif.redir_pc, sb_q.pop_front());
      end
    end
  end

  task automatic wait_ready(input string name);
    bit seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ex_ready) begin
        seen = 1;
        break;
      end
    end
    check({name, "_ready_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int rv = 0, fl = 0, fid = 0, mis = 0, rdy_at = 0;
    @(posedge clk); #1;
    ex_valid     = v.valid;
    ex_is_branch = v.br;
    ex_taken     = v.taken;
    ex_target    = v.target;
    if (v.exp_rv != 0) sb_q.push_back(v.target);
    @(negedge clk);
    check($sformatf("vec%0d pre_ready", idx), 32'(ex_ready), 32'd1);
    check($sformatf("vec%0d pre_stall", idx), 32'(stall_ex), 32'd0);
    @(posedge clk); #1;
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_taken     = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rv  += int'(rif.redir_valid);
      fl  += int'(flush_if);
      fid += int'(flush_id);
      mis += int'(misalign_exc);
      if (ex_ready && rdy_at == 0) rdy_at = k;
    end
    check($sformatf("vec%0d redir_cycles", idx), 32'(rv), 32'(v.exp_rv));
    check($sformatf("vec%0d flush_if_cycles", idx), 32'(fl), 32'(v.exp_fl));
    check($sformatf("vec%0d flush_id_cycles", idx), 32'(fid), 32'(v.exp_fl));
    check($sformatf("vec%0d misalign_cycles", idx), 32'(mis), 32'(v.exp_mis));
    check($sformatf("vec%0d ready_at", idx), 32'(rdy_at), 32'(v.exp_rdy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fl;
    bit seen;
    //                valid br   taken target          rv fl mis rdy
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 0, 0, 0, 1};  // not taken
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_0100, 1, 3, 0, 4};  // taken aligned
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_0102, 0, 0, 1, 1};  // misaligned
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0103, 0, 0, 1, 1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0101, 0, 0, 1, 1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0200, 0, 0, 0, 1};  // not a branch
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_0300, 0, 0, 0, 1};  // not valid
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1, 3, 0, 4};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h0000_0002, 0, 0, 0, 1};  // misaligned but not taken
    vecs[9] = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1, 3, 0, 4};

    rst_n           = 1'b0;
    ex_valid        = 1'b0;
    ex_is_branch    = 1'b0;
    ex_taken        = 1'b0;
    ex_target       = '0;
    rif.redir_ready = 1'b1;
    #3;
    check("rst ex_ready", 32'(ex_ready), 32'd1);
    check("rst redir_valid", 32'(rif.redir_valid), 32'd0);
    check("rst redir_pc", rif.redir_pc, 32'd0);
    check("rst flush_if", 32'(flush_if), 32'd0);
    check("rst flush_id", 32'(flush_id), 32'd0);
    check("rst misalign", 32'(misalign_exc), 32'd0);
    check("rst branch_cnt", 32'(branch_cnt), 32'd0);
    check("rst taken_cnt", 32'(taken_cnt), 32'd0);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

`ifdef BRANCH_STATS_EN
    check("table branch_cnt", 32'(branch_cnt), 32'd8);
    check("table taken_cnt", 32'(taken_cnt), 32'd3);
`else
    check("table branch_cnt", 32'(branch_cnt), 32'd0);
    check("table taken_cnt", 32'(taken_cnt), 32'd0);
`endif

    // Backpressure with a second branch waiting in EX.
    rif.redir_ready = 1'b0;
    @(posedge clk); #1;
    ex_valid     = 1'b1;
    ex_is_branch = 1'b1;
    ex_taken     = 1'b1;
    ex_target    = 32'h0000_0100;
    sb_q.push_back(32'h0000_0100);
    @(posedge clk); #1;
    ex_target = 32'h0000_0200;
    sb_q.push_back(32'h0000_0200);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp redir_valid", 32'(rif.redir_valid), 32'd1);
      check("bp redir_pc", rif.redir_pc, 32'h0000_0100);
      check("bp stall_ex", 32'(stall_ex), 32'd1);
      check("bp ex_ready", 32'(ex_ready), 32'd0);
    end
    @(posedge clk); #1;
    rif.redir_ready = 1'b1;
    fl   = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ex_ready) begin
        seen = 1;
        break;
      end
      if (flush_if && !rif.redir_valid) fl++;
    end
    check("bp ready_after_flush", 32'(seen), 32'd1);
    check("bp flush_only_cycles", 32'(fl), 32'd2);
    @(posedge clk); #1;
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_taken     = 1'b0;
    wait_ready("bp_second");

`ifdef BRANCH_STATS_EN
    check("bp branch_cnt", 32'(branch_cnt), 32'd10);
    check("bp taken_cnt", 32'(taken_cnt), 32'd5);
`endif

    // Reset while a redirect is held.
    rif.redir_ready = 1'b0;
    @(posedge clk); #1;
    ex_valid     = 1'b1;
    ex_is_branch = 1'b1;
    ex_taken     = 1'b1;
    ex_target    = 32'h0000_0400;
    @(posedge clk); #1;
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_taken     = 1'b0;
    @(negedge clk);
    check("mid redir_valid", 32'(rif.redir_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst redir_valid", 32'(rif.redir_valid), 32'd0);
    check("mid_rst redir_pc", rif.redir_pc, 32'd0);
    check("mid_rst flush_if", 32'(flush_if), 32'd0);
    check("mid_rst flush_id", 32'(flush_id), 32'd0);
    check("mid_rst misalign", 32'(misalign_exc), 32'd0);
    check("mid_rst ex_ready", 32'(ex_ready), 32'd1);
    check("mid_rst branch_cnt", 32'(branch_cnt), 32'd0);
    #3;
    rst_n           = 1'b1;
    rif.redir_ready = 1'b1;
    fl = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      fl += int'(rif.redir_valid) + int'(flush_if);
    end
    check("post_rst no_replay", 32'(fl), 32'd0);
    check("post_rst ex_ready", 32'(ex_ready), 32'd1);

    // Twenty taken aligned branches drive both counters into saturation.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      ex_valid     = 1'b1;
      ex_is_branch = 1'b1;
      ex_taken     = 1'b1;
      ex_target    = 32'(i + 1) << 4;
      sb_q.push_back(32'(i + 1) << 4);
      @(posedge clk); #1;
      ex_valid     = 1'b0;
      ex_is_branch = 1'b0;
      ex_taken     = 1'b0;
      wait_ready("sat");
    end
`ifdef BRANCH_STATS_EN
    check("sat branch_cnt", 32'(branch_cnt), 32'd15);
    check("sat taken_cnt", 32'(taken_cnt), 32'd15);
`else
    check("sat branch_cnt", 32'(branch_cnt), 32'd0);
    check("sat taken_cnt", 32'(taken_cnt), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("sb drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
